cal_seq_controller: RTL

Parametrised successor to the lab-4 calculator front-end controller. It sits between the board switches/buttons and the arithmetic datapath: it synchronises and edge-detects the raw buttons, captures operands from `bin`, and selects an operation (multiply, add, subtract). It issues a one-cycle `go` strobe to the datapath and supports chaining, where the previous datapath result becomes the next first operand.

---
 rtl/cal_pkg.sv | 68 ++++++
 rtl/cal_seq_controller_btn_edge.sv | 38 +++
 rtl/cal_seq_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cal_pkg.sv
// cal_pkg
// Shared constants and helpers for the calculator front-end controller.
//   - operation codes driven on the 'op' output
//   - FSM state constants driven on the 'state' output
//   - command type produced by the button decoder, plus small decode helpers
package cal_pkg;

  // Operation codes presented to the arithmetic datapath
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // FSM state encodings; 2'b11 is unreachable and recovers to IDLE
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OPSEL = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  // One decoded command per cycle, after priority resolution
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_CLR  = 3'd1,
    CMD_MUL  = 3'd2,
    CMD_ADD  = 3'd3,
    CMD_SUB  = 3'd4
  } cmd_e;

  // Priority decode of the enter/multiply/add edge pulses.
  // Enter wins; multiply and add landing in the same cycle mean subtract.
  function automatic cmd_e decode_cmd(input logic [2:0] edges);
    cmd_e cmd;
    if (edges[0]) begin
      cmd = CMD_CLR;
    end else if (edges[1] && edges[2]) begin
      cmd = CMD_SUB;
    end else if (edges[1]) begin
      cmd = CMD_MUL;
    end else if (edges[2]) begin
      cmd = CMD_ADD;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

  // True for commands that load a first operand and select an operation
  function automatic logic is_arith(input cmd_e cmd);
    logic r;
    case (cmd)
      CMD_MUL, CMD_ADD, CMD_SUB: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Map an arithmetic command onto its datapath operation code
  function automatic logic [1:0] cmd_to_op(input cmd_e cmd);
    logic [1:0] r;
    case (cmd)
      CMD_MUL: r = OP_MUL;
      CMD_ADD: r = OP_ADD;
      CMD_SUB: r = OP_SUB;
      default: r = OP_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cal_seq_controller_btn_edge.sv
// btn_edge
// Brings N raw asynchronous buttons into the mclk domain through a SYNC-deep
// flop chain and turns each rising level into a single-cycle pulse.
// Ports:
//   mclk  - clock
//   rst_n - asynchronous active-low reset
//   btn   - raw active-high buttons
//   pulse - one-cycle pulse per synchronised rising edge
// The pulse is taken directly from the last synchroniser stage and the
// history flop so that a command acts on the edge after it appears there;
// both inputs to the AND are flops, so the pulse is glitch-free.
module btn_edge #(
  parameter int N    = 4,
  parameter int SYNC = 2
) (
  input  logic         mclk,
  input  logic         rst_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] pulse
);

  logic [SYNC-1:0][N-1:0] sync_r;
  logic [N-1:0]           prev_r;

  // Synchroniser chain (stage 0 samples the pins) plus one-cycle history
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {(SYNC*N){1'b0}};
      prev_r <= {N{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC-2:0], btn};
      prev_r <= sync_r[SYNC-1];
    end
  end

  assign pulse = sync_r[SYNC-1] & ~prev_r;

endmodule

// File: rtl/cal_seq_controller.sv
// cal_seq_controller
// Front-end controller for the board calculator: captures operands from the
// switches, selects the operation from the buttons and strobes the datapath.
// Ports:
//   mclk    - clock (rising edge)
//   rst_n   - asynchronous active-low reset
//   bin     - operand switches (quasi-static, sampled directly)
//   btn     - raw buttons: [0] enter/clear, [1] mul, [2] add, [3] enable toggle
//   result  - datapath result, low W bits reused as next first operand
//   x, y    - first / second operand to the datapath
//   op      - operation code (cal_pkg OP_*)
//   go      - one-cycle strobe, x/y/op valid in the same cycle
//   enabled - calculator active
//   state   - FSM state for LEDs and debug
module cal_seq_controller
  import cal_pkg::*;
#(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic           mclk,
  input  logic           rst_n,
  input  logic [W-1:0]   bin,
  input  logic [3:0]     btn,
  input  logic [2*W-1:0] result,
  output logic [W-1:0]   x,
  output logic [W-1:0]   y,
  output logic [1:0]     op,
  output logic           go,
  output logic           enabled,
  output logic [1:0]     state
);

  logic [3:0]   edge_s;
  cmd_e         cmd_s;
  logic [W-1:0] chain_s;

  logic [1:0]   state_r,   state_s;
  logic [W-1:0] x_r,       x_s;
  logic [W-1:0] y_r,       y_s;
  logic [1:0]   op_r,      op_s;
  logic         go_r,      go_s;
  logic         enabled_r, enabled_s;

  btn_edge #(
    .N    (4),
    .SYNC (SYNC)
  ) u_btn_edge (
    .mclk  (mclk),
    .rst_n (rst_n),
    .btn   (btn),
    .pulse (edge_s)
  );

  // Upper half of the product/sum is dropped when chaining
  assign chain_s = W'(result);
  assign cmd_s   = decode_cmd(edge_s[2:0]);

  // Next-state and next-output decode
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    y_s       = y_r;
    op_s      = op_r;
    go_s      = 1'b0;
    enabled_s = enabled_r;

    if (edge_s[3]) begin
      // Enable toggle masks every other button edge in this cycle; both
      // directions land in a clean IDLE.
      enabled_s = ~enabled_r;
      state_s   = IDLE;
      x_s       = {W{1'b0}};
      y_s       = {W{1'b0}};
      op_s      = OP_NONE;
    end else if (!enabled_r) begin
      state_s   = IDLE;
      x_s       = {W{1'b0}};
      y_s       = {W{1'b0}};
      op_s      = OP_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_arith(cmd_s)) begin
            x_s     = bin;
            y_s     = {W{1'b0}};
            op_s    = cmd_to_op(cmd_s);
            state_s = OPSEL;
          end else begin
            state_s = IDLE;
          end
        end
        OPSEL: begin
          if (cmd_s == CMD_CLR) begin
            y_s     = bin;
            go_s    = 1'b1;
            state_s = DONE;
          end else if (is_arith(cmd_s)) begin
            // Re-entry of the first operand while still choosing
            x_s     = bin;
            op_s    = cmd_to_op(cmd_s);
            state_s = OPSEL;
          end else begin
            state_s = OPSEL;
          end
        end
        DONE: begin
          if (cmd_s == CMD_CLR) begin
            x_s     = {W{1'b0}};
            y_s     = {W{1'b0}};
            op_s    = OP_NONE;
            state_s = IDLE;
          end else if (is_arith(cmd_s)) begin
            x_s     = chain_s;
            y_s     = {W{1'b0}};
            op_s    = cmd_to_op(cmd_s);
            state_s = OPSEL;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a cleared IDLE
          state_s = IDLE;
          x_s     = {W{1'b0}};
          y_s     = {W{1'b0}};
          op_s    = OP_NONE;
        end
      endcase
    end
  end

  // Controller state and registered outputs
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      x_r       <= {W{1'b0}};
      y_r       <= {W{1'b0}};
      op_r      <= OP_NONE;
      go_r      <= 1'b0;
      enabled_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      x_r       <= x_s;
      y_r       <= y_s;
      op_r      <= op_s;
      go_r      <= go_s;
      enabled_r <= enabled_s;
    end
  end

  assign x       = x_r;
  assign y       = y_r;
  assign op      = op_r;
  assign go      = go_r;
  assign enabled = enabled_r;
  assign state   = state_r;

endmodule
